// File: rtl/execute_cycle.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch/jump
// resolution and the EX/MEM pipeline register with stall and bubble control.
module execute_cycle #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidE,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic [2:0]            ALUControlE,
  input  logic                  ALUSrcE,
  input  logic                  BranchE,
  input  logic                  JumpE,
  input  logic                  JalrE,
  input  logic [2:0]            Funct3E,
  input  logic [XLEN-1:0]       RD1_E,
  input  logic [XLEN-1:0]       RD2_E,
  input  logic [XLEN-1:0]       ImmExtE,
  input  logic [XLEN-1:0]       PCE,
  input  logic [XLEN-1:0]       PCPlus4E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [XLEN-1:0]       ResultW,
  input  logic                  StallM,
  input  logic                  BubbleM,
  output logic                  PCSrcE,
  output logic [XLEN-1:0]       PCTargetE,
  output logic                  ValidM,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcM,
  output logic [REG_ADDR_W-1:0] RD_M,
  output logic [XLEN-1:0]       ALUResultM,
  output logic [XLEN-1:0]       WriteDataM,
  output logic [XLEN-1:0]       PCPlus4M
);

  localparam logic [XLEN-1:0] LsbClearMask = {{(XLEN-1){1'b1}}, 1'b0};

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] jalr_sum;
  logic [4:0]      shamt;
  logic            zero;
  logic            branch_cond;

  logic                  valid_q, regwrite_q, memwrite_q;
  logic [1:0]            resultsrc_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       alu_result_q, write_data_q, pc_plus4_q;

  // Reserved select 2'b11 falls back to the register-file value.
  always_comb begin
    src_a = RD1_E;
    unique case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_result_q;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = RD2_E;
    unique case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = alu_result_q;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : fwd_b;
  assign shamt = src_b[4:0];

  always_comb begin
    alu_result = '0;
    unique case (ALUControlE)
      3'b000: alu_result = src_a + src_b;
      3'b001: alu_result = src_a - src_b;
      3'b010: alu_result = src_a & src_b;
      3'b011: alu_result = src_a | src_b;
      3'b100: alu_result = src_a ^ src_b;
      3'b101: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b110: alu_result = src_a << shamt;
      3'b111: alu_result = src_a >> shamt;
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  always_comb begin
    branch_cond = 1'b0;
    case (Funct3E)
      3'b000:  branch_cond = zero;
      3'b001:  branch_cond = !zero;
      3'b100:  branch_cond = alu_result[0];
      3'b101:  branch_cond = !alu_result[0];
      default: branch_cond = 1'b0;
    endcase
  end

  assign jalr_sum  = src_a + ImmExtE;
  assign PCSrcE    = rst & ValidE & (JumpE | (BranchE & branch_cond));
  assign PCTargetE = (JumpE & JalrE) ? (jalr_sum & LsbClearMask) : (PCE + ImmExtE);

  // Stall outranks bubble so a held instruction is never lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      resultsrc_q  <= '0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else if (!StallM) begin
      if (BubbleM) begin
        valid_q      <= 1'b0;
        regwrite_q   <= 1'b0;
        memwrite_q   <= 1'b0;
        resultsrc_q  <= '0;
        rd_q         <= '0;
        alu_result_q <= '0;
        write_data_q <= '0;
        pc_plus4_q   <= '0;
      end else begin
        valid_q      <= ValidE;
        regwrite_q   <= RegWriteE & ValidE;
        memwrite_q   <= MemWriteE & ValidE;
        resultsrc_q  <= ResultSrcE;
        rd_q         <= RD_E;
        alu_result_q <= alu_result;
        write_data_q <= fwd_b;
        pc_plus4_q   <= PCPlus4E;
      end
    end
  end

  assign ValidM     = valid_q;
  assign RegWriteM  = regwrite_q;
  assign MemWriteM  = memwrite_q;
  assign ResultSrcM = resultsrc_q;
  assign RD_M       = rd_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;

endmodule
